// File: rtl/mc_proc_controller.sv
// Multicycle control FSM: sequences one shared memory port through FETCH/DECODE/EXEC/MEM/WB.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instr_ret performance counters.
module mc_proc_controller #(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned WAIT_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instr,
  input  logic                  alu_out,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  rf_we,
  output logic [1:0]            rf_wr_sel,
  output logic [3:0]            rf_rd0_idx,
  output logic [3:0]            rf_rd1_idx,
  output logic [3:0]            rf_wr_idx,
  output logic [3:0]            alu_func,
  output logic                  alu_alt_op,
  output logic                  alu_src2_sel,
  output logic [15:0]           imm,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instr_ret
`endif
);

  localparam logic [3:0] OP_ALU_R  = 4'h0;
  localparam logic [3:0] OP_ALU_I  = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h9;
  localparam logic [3:0] OP_CMP_R  = 4'h2;
  localparam logic [3:0] OP_CMP_I  = 4'hA;
  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_JAL    = 4'hB;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WR_ALU    = 2'b00;
  localparam logic [1:0] WR_MEM    = 2'b01;
  localparam logic [1:0] WR_LINK   = 2'b10;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;

  logic [3:0] opcode;
  logic       is_alu, is_cmp, is_load, is_store, is_branch, is_jal;
  logic       is_legal, uses_imm, rd_swap;

  // Instruction class decode
  assign opcode    = instr[3:0];
  assign is_alu    = (opcode == OP_ALU_R) || (opcode == OP_ALU_I);
  assign is_cmp    = (opcode == OP_CMP_R) || (opcode == OP_CMP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_legal  = is_alu || is_cmp || is_load || is_store || is_branch || is_jal;
  assign uses_imm  = (opcode == OP_ALU_I) || (opcode == OP_CMP_I) || is_load || is_store || is_jal;
  assign rd_swap   = is_store || is_branch;

  // Stores and branches read rd as a source, so both read ports shift up one field
  assign rf_rd0_idx = rd_swap ? instr[31:28] : instr[27:24];
  assign rf_rd1_idx = rd_swap ? instr[27:24] : instr[23:20];
  assign rf_wr_idx  = instr[31:28];
  assign alu_func   = instr[7:4];
  assign imm        = instr[23:8];

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next state and strobes; the wait counter is zero whenever no request is stalled
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEQ;
    rf_we        = 1'b0;
    rf_wr_sel    = WR_ALU;
    alu_alt_op   = 1'b0;
    alu_src2_sel = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (!is_legal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src2_sel = uses_imm;
        alu_alt_op   = is_cmp || is_branch;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = alu_out ? PC_BRANCH : PC_SEQ;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        rf_wr_sel = is_load ? WR_MEM : (is_jal ? WR_LINK : WR_ALU);
        pc_sel    = is_jal ? PC_JUMP : PC_SEQ;
        state_d   = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    endcase

    // Strobes drop the moment reset asserts, even mid-transaction
    if (!reset_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_SEQ;
      rf_we        = 1'b0;
      rf_wr_sel    = WR_ALU;
      alu_alt_op   = 1'b0;
      alu_src2_sel = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_ret_q, instr_ret_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      instr_ret_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_ret_q <= instr_ret_d;
    end
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_ret_d = instr_ret_q;
    if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (pc_we)             instr_ret_d = instr_ret_q + 32'd1;
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_ret = instr_ret_q;
`endif

endmodule
